// File: rtl/surf_cout_tx.sv
// COUT nibble transmitter: serializes 32-bit words MSB-nibble-first over an
// 8-cycle frame aligned to sync_i, sending a training word while disabled.
module surf_cout_tx #(
   parameter logic [31:0] TRAIN_PATTERN = 32'hA55A6996,
   parameter logic [31:0] IDLE_WORD     = 32'h00000000
) (
   input  logic        sysclk_i,
   input  logic        rst_n_i,
   input  logic        sync_i,
   input  logic        enable_i,
   input  logic [31:0] data_i,
   input  logic        valid_i,
   output logic        ready_o,
   output logic [3:0]  cout_o,
   output logic        aligned_o,
   output logic        sync_err_o,
   output logic [15:0] word_count_o
);

   logic [2:0]  phase_q, phase_d;
   logic [31:0] sreg_q, sreg_d;
   logic [3:0]  cout_q, cout_d;
   logic        aligned_q, aligned_d;
   logic        sync_err_q, sync_err_d;
   logic [15:0] word_count_q, word_count_d;

   logic        load_cycle;
   logic        accept;
   logic [31:0] word_sel;
   logic [31:0] sreg_shifted;

   // A sync pulse always starts a new frame; the natural boundary only counts once aligned.
   assign load_cycle = sync_i | ((phase_q == 3'd7) & aligned_q);
   assign ready_o    = enable_i & load_cycle;
   assign accept     = ready_o & valid_i;

   always_comb begin
      word_sel = IDLE_WORD;
      if (!enable_i) begin
         word_sel = TRAIN_PATTERN;
      end else if (valid_i) begin
         word_sel = data_i;
      end
   end

   // Nibble that belongs to the phase about to start.
   assign sreg_shifted = sreg_q << {phase_q + 3'd1, 2'b00};

   always_comb begin
      phase_d      = phase_q + 3'd1;
      sreg_d       = sreg_q;
      cout_d       = 4'h0;
      aligned_d    = aligned_q | sync_i;
      sync_err_d   = sync_i & aligned_q & (phase_q != 3'd7);
      word_count_d = word_count_q + {15'd0, accept};
      if (load_cycle) begin
         phase_d = 3'd0;
         sreg_d  = word_sel;
         cout_d  = word_sel[31:28];
      end else if (aligned_q) begin
         cout_d  = sreg_shifted[31:28];
      end
   end

   always_ff @(posedge sysclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase_q      <= 3'd0;
         sreg_q       <= 32'd0;
         cout_q       <= 4'h0;
         aligned_q    <= 1'b0;
         sync_err_q   <= 1'b0;
         word_count_q <= 16'd0;
      end else begin
         phase_q      <= phase_d;
         sreg_q       <= sreg_d;
         cout_q       <= cout_d;
         aligned_q    <= aligned_d;
         sync_err_q   <= sync_err_d;
         word_count_q <= word_count_d;
      end
   end

   assign cout_o       = cout_q;
   assign aligned_o    = aligned_q;
   assign sync_err_o   = sync_err_q;
   assign word_count_o = word_count_q;

endmodule

// File: tb/tb_surf_cout_tx.sv
// Directed bench for surf_cout_tx: training, data, idle, resync error,
// enable drop, counter wrap and asynchronous reset mid-word.
module tb_surf_cout_tx;

   localparam logic [31:0] TRAIN = 32'hA55A6996;

   logic        sysclk_i = 1'b0;
   logic        rst_n_i  = 1'b0;
   logic        sync_i   = 1'b0;
   logic        enable_i = 1'b0;
   logic [31:0] data_i   = 32'd0;
   logic        valid_i  = 1'b0;
   logic        ready_o;
   logic [3:0]  cout_o;
   logic        aligned_o;
   logic        sync_err_o;
   logic [15:0] word_count_o;

   int checks    = 0;
   int errors    = 0;
   int exp_count = 0;

   surf_cout_tx dut (
      .sysclk_i     (sysclk_i),
      .rst_n_i      (rst_n_i),
      .sync_i       (sync_i),
      .enable_i     (enable_i),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .cout_o       (cout_o),
      .aligned_o    (aligned_o),
      .sync_err_o   (sync_err_o),
      .word_count_o (word_count_o)
   );

   always #5 sysclk_i = ~sysclk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] nib(input logic [31:0] w, input int p);
      logic [31:0] t;
      t = w >> (28 - 4 * p);
      return t[3:0];
   endfunction

   // One clock cycle: drive inputs, check ready mid-cycle, check registered outputs after the edge.
   task automatic step(input logic s, input logic e, input logic v, input logic [31:0] d,
                       input logic exp_rdy, input logic [3:0] exp_cout, input logic exp_err,
                       input string tag);
      sync_i   = s;
      enable_i = e;
      valid_i  = v;
      data_i   = d;
      #2;
      check_val({tag, " ready"}, {31'd0, ready_o}, {31'd0, exp_rdy});
      @(posedge sysclk_i);
      #1;
      check_val({tag, " cout"}, {28'd0, cout_o}, {28'd0, exp_cout});
      check_val({tag, " sync_err"}, {31'd0, sync_err_o}, {31'd0, exp_err});
      $display("%s: sync=%b en=%b valid=%b ready=%b cout=%h err=%b count=%0d",
               tag, s, e, v, exp_rdy, cout_o, sync_err_o, word_count_o);
   endtask

   // One 8-cycle frame, sync on the load cycle, inputs held for the whole frame.
   task automatic frame(input logic e, input logic v, input logic [31:0] d,
                        input logic [31:0] exp_word, input string tag);
      for (int p = 0; p < 8; p++) begin
         step(p == 0, e, v, d, e && (p == 0), nib(exp_word, p), 1'b0, tag);
      end
      if (e && v) exp_count++;
   endtask

   initial begin
      // Reset state; ready is combinational even during reset.
      sync_i   = 1'b1;
      enable_i = 1'b1;
      #2;
      check_val("rst ready", {31'd0, ready_o}, 32'd1);
      check_val("rst cout", {28'd0, cout_o}, 32'd0);
      check_val("rst aligned", {31'd0, aligned_o}, 32'd0);
      check_val("rst sync_err", {31'd0, sync_err_o}, 32'd0);
      check_val("rst count", {16'd0, word_count_o}, 32'd0);
      sync_i   = 1'b0;
      enable_i = 1'b0;
      @(posedge sysclk_i);
      @(posedge sysclk_i);
      #1;
      rst_n_i = 1'b1;

      // Training before and after alignment.
      repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 4'h0, 1'b0, "pre_align");
      check_val("pre_align aligned", {31'd0, aligned_o}, 32'd0);
      frame(1'b0, 1'b0, 32'd0, TRAIN, "train0");
      check_val("train aligned", {31'd0, aligned_o}, 32'd1);
      frame(1'b0, 1'b0, 32'd0, TRAIN, "train1");

      // Back-to-back data words.
      frame(1'b1, 1'b1, 32'h12345678, 32'h12345678, "data0");
      frame(1'b1, 1'b1, 32'h9ABCDEF0, 32'h9ABCDEF0, "data1");
      check_val("data count", {16'd0, word_count_o}, 32'd2);

      // Enabled with nothing offered sends idle.
      frame(1'b1, 1'b0, 32'h55555555, 32'd0, "idle0");
      frame(1'b1, 1'b0, 32'h55555555, 32'd0, "idle1");
      check_val("idle count", {16'd0, word_count_o}, 32'd2);

      // Early sync at phase 3 abandons the word in flight.
      for (int p = 0; p < 4; p++)
         step(p == 0, 1'b1, 1'b1, 32'hFFFFFFFF, p == 0, 4'hF, 1'b0, "resync_pre");
      exp_count++;
      step(1'b1, 1'b1, 1'b1, 32'h00000000, 1'b1, 4'h0, 1'b1, "resync");
      exp_count++;
      for (int p = 1; p < 8; p++)
         step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 4'h0, 1'b0, "resync_post");
      frame(1'b1, 1'b0, 32'd0, 32'd0, "resync_idle");
      check_val("resync count", {16'd0, word_count_o}, exp_count);

      // Enable dropped mid-word does not disturb the word in flight.
      step(1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 4'hD, 1'b0, "endrop");
      step(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 4'hE, 1'b0, "endrop");
      for (int p = 2; p < 8; p++)
         step(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, nib(32'hDEADBEEF, p), 1'b0, "endrop");
      exp_count++;
      frame(1'b0, 1'b1, 32'hDEADBEEF, TRAIN, "endrop_train");
      check_val("endrop count", {16'd0, word_count_o}, exp_count);

      // Counter wrap: sync every cycle loads and accepts a word each cycle.
      sync_i   = 1'b1;
      enable_i = 1'b1;
      valid_i  = 1'b1;
      data_i   = 32'h0F0F0F0F;
      repeat (65535 - exp_count) begin
         @(posedge sysclk_i);
      end
      #1;
      exp_count = 65535;
      check_val("wrap pre count", {16'd0, word_count_o}, 32'h0000FFFF);
      check_val("wrap repeated sync_err", {31'd0, sync_err_o}, 32'd1);
      for (int p = 1; p < 8; p++)
         step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, nib(32'h0F0F0F0F, p), 1'b0, "wrap_fill");
      frame(1'b1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D, "wrap");
      check_val("wrap count", {16'd0, word_count_o}, 32'd0);

      // Asynchronous reset mid-word, then realignment needs a new sync.
      step(1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1, 4'h1, 1'b0, "arst_word");
      step(1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0, 4'h1, 1'b0, "arst_word");
      sync_i = 1'b0;
      #2;
      rst_n_i = 1'b0;
      #1;
      check_val("arst cout", {28'd0, cout_o}, 32'd0);
      check_val("arst aligned", {31'd0, aligned_o}, 32'd0);
      check_val("arst count", {16'd0, word_count_o}, 32'd0);
      check_val("arst ready", {31'd0, ready_o}, 32'd0);
      @(posedge sysclk_i);
      #1;
      rst_n_i = 1'b1;
      repeat (10) step(1'b0, 1'b1, 1'b1, 32'h22222222, 1'b0, 4'h0, 1'b0, "post_rst");
      check_val("post_rst aligned", {31'd0, aligned_o}, 32'd0);
      check_val("post_rst count", {16'd0, word_count_o}, 32'd0);
      frame(1'b0, 1'b0, 32'd0, TRAIN, "realign");
      check_val("realign aligned", {31'd0, aligned_o}, 32'd1);
      check_val("realign count", {16'd0, word_count_o}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
